mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access unit for the MEM stage: it receives the `store`/`load`/`memory_mode` controls produced by the opcode decoder, together with the address and store data. It runs word-wide transactions on a req/ack data-memory port, performing read-modify-write for sub-word stores and sign/zero extension for loads. It stalls the pipeline through `busy` and reports completion with a one-cycle `done` pulse.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: MEM-stage request; the requester holds it and all request fields stable until `done`.
- `load`, `store` in 1 each: decoder outputs.
- `memory_mode` in 3: opcode[2:0]: 000 byte, 001 half, 011 word, 100 byte unsigned, 101 half unsigned.
- `addr` in ADDR_WIDTH: byte address.
- `wdata` in 32: store data, right-aligned.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: high with `done` for a rejected request.
- `rdata` out 32: extended load result; valid with `done`, held until the next `done`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_WIDTH, `mem_wdata` out 32: memory request, all registered; `mem_addr[1:0]` is always 0.
- `mem_rdata` in 32, `mem_ack` in 1: memory response; the read data is valid in the cycle `mem_ack` is high.

## Operation
- Memory is little-endian: the byte at `addr[1:0]`=k occupies bits [8k+7:8k].
- States: IDLE, READ, WRITE, DONE, ERR.
- **IDLE:** a request is accepted when `req_valid` is high; the next state is chosen from the request:
  - Rejected → ERR if any of:
    - `load` and `store` are both high, or both are low;
    - mode is 010, 110 or 111;
    - a store uses mode 100 or 101;
    - a half access has `addr[0]`=1;
    - a word access has `addr[1:0]`≠0.
  - Load or sub-word store → READ, with `mem_req`=1 and `mem_we`=0.
  - Word store → WRITE, with `mem_req`=1, `mem_we`=1 and `mem_wdata`=`wdata`.
- **READ:** hold until `mem_ack`.
  - Load: latch the extended lane into `rdata` → DONE.
  - Sub-word store: merge `wdata[7:0]` or `wdata[15:0]` into the addressed lane of `mem_rdata`, drive the merged word on `mem_wdata` with `mem_we`=1 → WRITE. `mem_req` stays high.
- **WRITE:** hold until `mem_ack` → DONE. Stores leave `rdata` unchanged.
- **DONE:** `done`=1, `mem_req`=0, `req_valid` ignored → IDLE. The requester drops or replaces its request in the cycle after `done`.
- **ERR:** `done`=1, `error`=1, `rdata` unchanged, no memory transaction → IDLE.
- Extension: modes 000/001 sign-extend from bit 7/15; modes 100/101 zero-extend.
- `mem_addr` = {`addr`[ADDR_WIDTH-1:2], 2'b00} for the whole transaction.
- Each cycle with `mem_ack`=1 while `mem_req`=1 completes exactly one transaction. `mem_ack` outside READ/WRITE is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `mem_req`, `mem_we` all 0; `rdata`, `mem_addr`, `mem_wdata` all 0.
- Reset mid-transaction abandons it immediately: `mem_req` drops asynchronously and no `done` is produced.
- Accept at cycle T; N = number of wait cycles before `mem_ack` (0 = ack in the first request cycle):
  - Load: `mem_req` high T+1..T+1+N; `done` at T+2+N.
  - Word store: same as load.
  - Sub-word store: READ T+1..T+1+N1, WRITE T+2+N1..T+2+N1+N2; `done` at T+3+N1+N2.
  - Error: `done`=`error`=1 at T+1.
- Back-to-back requests: the earliest re-accept is the cycle after `done`, so there is one bubble between requests.

## Test plan
- Load-byte sign extension: memory word 0x80FF7F01, lb at addr 0x103, ack with no wait → `mem_addr`=0x100, `rdata`=0xFFFFFF80, `done` at T+2.
- lhu at 0x102 on the same word → `rdata`=0x000080FF. lh at 0x102 → `rdata`=0xFFFF80FF.
- sb of 0xAB at 0x101 on word 0x11223344, ack with 2 wait cycles on each leg:
  - a read, then a write with `mem_wdata`=0x1122AB44;
  - `done` at T+7.
- sw of 0xDEADBEEF at 0x20, no wait → a single write, `done` at T+2. Then lw at 0x20 → `rdata`=0xDEADBEEF.
- Each of: lw at 0x22, sh at 0x31, mode 010, load and store both high → `error`=`done`=1 at T+1, `mem_req` never asserted, `rdata` unchanged.
- Assert `rst` during WRITE wait → `mem_req`=0 immediately and no `done`. After release, lw completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage data-memory access unit. Turns decoded load/store requests into
// word-wide transactions on a req/ack memory port. Sub-word stores are done
// as read-modify-write, and loads are sign- or zero-extended. All outputs are
// registered. Illegal requests complete through the ERR state with error=1.

module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  load,
  input  logic                  store,
  input  logic [2:0]            memory_mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  // Access modes as carried in opcode[2:0]
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b011;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Lane helpers (little-endian: byte k lives in bits [8k+7:8k])
  // ---------------------------------------------------------------------------

  // Pick the addressed byte lane out of a memory word
  function automatic logic [7:0] f_lane_byte(input logic [31:0] word,
                                             input logic [1:0]  off);
    logic [7:0] res;
    case (off)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      2'd3:    res = word[31:24];
      default: res = word[7:0];
    endcase
    return res;
  endfunction

  // Pick the addressed half-word lane; off[0] is known to be zero here
  function automatic logic [15:0] f_lane_half(input logic [31:0] word,
                                              input logic [1:0]  off);
    logic [15:0] res;
    if (off[1]) begin
      res = word[31:16];
    end else begin
      res = word[15:0];
    end
    return res;
  endfunction

  // Extract the addressed lane and sign/zero extend it to 32 bits
  function automatic logic [31:0] f_extend(input logic [31:0] word,
                                           input logic [2:0]  mode,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = f_lane_byte(word, off);
    h = f_lane_half(word, off);
    case (mode)
      MODE_B:  res = {{24{b[7]}}, b};
      MODE_H:  res = {{16{h[15]}}, h};
      MODE_BU: res = {24'h00_0000, b};
      MODE_HU: res = {16'h0000, h};
      MODE_W:  res = word;
      default: res = word;
    endcase
    return res;
  endfunction

  // Merge right-aligned store data into the addressed lane of a memory word
  function automatic logic [31:0] f_merge(input logic [31:0] word,
                                          input logic [31:0] data,
                                          input logic [2:0]  mode,
                                          input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (mode)
      MODE_B: begin
        case (off)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          2'd3:    res[31:24] = data[7:0];
          default: res        = word;
        endcase
      end
      MODE_H: begin
        if (off[1]) begin
          res[31:16] = data[15:0];
        end else begin
          res[15:0] = data[15:0];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [31:0]           r_rdata;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  // Request fields captured at accept time for use in later states
  logic                  r_is_load;
  logic [2:0]            r_mode;
  logic [1:0]            r_off;
  logic [31:0]           r_wdata;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                  w_is_half;
  logic                  w_is_word;
  logic                  w_bad_mode;
  logic                  w_bad_op;
  logic                  w_bad_sign;
  logic                  w_misalign;
  logic                  w_reject;
  logic                  w_word_store;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  // Classify the incoming request and decide whether it must be rejected
  always_comb begin
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    w_bad_mode = 1'b0;
    case (memory_mode)
      MODE_B, MODE_BU: w_is_half  = 1'b0;
      MODE_H, MODE_HU: w_is_half  = 1'b1;
      MODE_W:          w_is_word  = 1'b1;
      default:         w_bad_mode = 1'b1;
    endcase
    // Exactly one of load/store must be set
    w_bad_op     = (load == store);
    // Unsigned modes only make sense for loads
    w_bad_sign   = store & memory_mode[2];
    w_misalign   = (w_is_half & addr[0]) |
                   (w_is_word & (addr[1:0] != 2'b00));
    w_reject     = w_bad_op | w_bad_mode | w_bad_sign | w_misalign;
    w_word_store = store & ~load & w_is_word;
    w_word_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
  end

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs
  // ---------------------------------------------------------------------------

  // Sequence accept -> (read) -> (write) -> done/err and drive the memory port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_is_load   <= 1'b0;
      r_mode      <= 3'b000;
      r_off       <= 2'b00;
      r_wdata     <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          if (req_valid) begin
            r_busy <= 1'b1;
            if (w_reject) begin
              // Rejected request: report immediately, memory port untouched
              r_state <= ST_ERR;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_is_load  <= load;
              r_mode     <= memory_mode;
              r_off      <= addr[1:0];
              r_wdata    <= wdata;
              r_mem_addr <= w_word_addr;
              r_mem_req  <= 1'b1;
              if (w_word_store) begin
                // Full-word store needs no read leg
                r_mem_we    <= 1'b1;
                r_mem_wdata <= wdata;
                r_state     <= ST_WRITE;
              end else begin
                r_mem_we <= 1'b0;
                r_state  <= ST_READ;
              end
            end
          end else begin
            r_busy <= 1'b0;
          end
        end

        ST_READ: begin
          if (mem_ack) begin
            if (r_is_load) begin
              r_rdata   <= f_extend(mem_rdata, r_mode, r_off);
              r_mem_req <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              // Sub-word store: keep mem_req high and issue the merged write
              r_mem_wdata <= f_merge(mem_rdata, r_wdata, r_mode, r_off);
              r_mem_we    <= 1'b1;
              r_state     <= ST_WRITE;
            end
          end else begin
            r_state <= ST_READ;
          end
        end

        ST_WRITE: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_WRITE;
          end
        end

        ST_DONE: begin
          // One-cycle completion pulse; the request is ignored here
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_ERR: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_error   <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
